// File: rtl/decode_inst_buffer.sv
// Instruction buffer between the fetch-to-decode handshake and decode/rename.
// A small circular queue that absorbs decode stalls, optionally bypasses the
// enqueue data straight to the output when empty, and on a redirect drops only
// the entries younger than the squashing sequence number.
//
// Handshake: a transfer happens on a side exactly when valid & ready are both
// high at the rising clock edge; valid never waits on ready, and f_rdy depends
// only on the registered count (no path from d_rdy or squash_val).
module decode_inst_buffer #(
    parameter int p_depth        = 4,
    parameter int p_seq_num_bits = 8,
    parameter int p_bypass       = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 f_val,
    output logic                                 f_rdy,
    input  logic [31:0]                          f_inst,
    input  logic [31:0]                          f_pc,
    input  logic [p_seq_num_bits-1:0]            f_seq_num,
    output logic                                 d_val,
    input  logic                                 d_rdy,
    output logic [31:0]                          d_inst,
    output logic [31:0]                          d_pc,
    output logic [p_seq_num_bits-1:0]            d_seq_num,
    input  logic                                 squash_val,
    input  logic [p_seq_num_bits-1:0]            squash_seq_num,
    output logic [$clog2(p_depth+1)-1:0]         occupancy
);

    localparam int PW = $clog2(p_depth);
    localparam int CW = $clog2(p_depth + 1);
    localparam int SW = p_seq_num_bits;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(p_depth);

    // Entry storage; contents are don't-care until written, so no reset.
    logic [31:0]   inst_q [p_depth];
    logic [31:0]   pc_q   [p_depth];
    logic [SW-1:0] seq_q  [p_depth];

    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    cnt_t count_q, count_d;

    logic empty;
    logic bypass_sel;
    logic f_xfer;
    logic d_xfer;
    logic deq;
    logic bypass_xfer;
    logic f_keep;
    logic wr_en;
    ptr_t wr_ptr;
    cnt_t cnt_deq;
    cnt_t cnt_sq;
    logic found;

    // Modular age test: e is younger than s when (e - s) is nonzero and in the
    // lower half of the sequence space.
    function automatic logic is_younger(input logic [SW-1:0] e, input logic [SW-1:0] s);
        logic [SW-1:0] diff;
        diff = e - s;
        return (diff != '0) && !diff[SW-1];
    endfunction

    // Handshake outputs, head/bypass data selection and transfer qualifiers.
    always_comb begin
        empty       = (count_q == '0);
        bypass_sel  = (p_bypass != 0) && empty;
        f_rdy       = (count_q != DEPTH_C);
        d_val       = !empty || (bypass_sel && f_val);
        d_inst      = bypass_sel ? f_inst    : inst_q[head_q];
        d_pc        = bypass_sel ? f_pc      : pc_q[head_q];
        d_seq_num   = bypass_sel ? f_seq_num : seq_q[head_q];
        f_xfer      = f_val && f_rdy;
        d_xfer      = d_val && d_rdy;
        deq         = d_xfer && !empty;
        bypass_xfer = bypass_sel && f_xfer && d_xfer;
        // An instruction arriving alongside a squash that it is younger than
        // belongs to the squashed path and is discarded.
        f_keep      = !(squash_val && is_younger(f_seq_num, squash_seq_num));
        wr_en       = f_xfer && !bypass_xfer && f_keep;
        occupancy   = count_q;
    end

    // Next pointers/count: dequeue first, then cut at the oldest younger entry,
    // then append the incoming instruction at the (possibly pulled-back) tail.
    always_comb begin
        head_d  = deq ? head_q + ptr_t'(1) : head_q;
        cnt_deq = deq ? count_q - cnt_t'(1) : count_q;
        cnt_sq  = cnt_deq;
        found   = 1'b0;
        if (squash_val) begin
            for (int i = 0; i < p_depth; i++) begin
                if (!found && (i < int'(cnt_deq)) &&
                    is_younger(seq_q[head_d + ptr_t'(i)], squash_seq_num)) begin
                    cnt_sq = cnt_t'(i);
                    found  = 1'b1;
                end
            end
        end
        wr_ptr  = head_d + ptr_t'(cnt_sq);
        tail_d  = wr_en ? wr_ptr + ptr_t'(1) : wr_ptr;
        count_d = wr_en ? cnt_sq + cnt_t'(1) : cnt_sq;
    end

    // Control state; reset empties the buffer immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry write at the computed tail slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            inst_q[wr_ptr] <= f_inst;
            pc_q[wr_ptr]   <= f_pc;
            seq_q[wr_ptr]  <= f_seq_num;
        end
    end

endmodule

// File: tb/tb_decode_inst_buffer.sv
// Bench for decode_inst_buffer: a vector table of per-cycle stimulus with the
// expected handshake/occupancy/head state, a queue-based scoreboard of
// enqueued instructions checked as they leave, and hand-written sequences for
// bypass latency and asynchronous reset.
module tb_decode_inst_buffer;

    localparam int W = 72; // {seq[7:0], pc[31:0], inst[31:0]}

    logic        clk;
    logic        rst;
    logic        f_val;
    logic [31:0] f_inst;
    logic [31:0] f_pc;
    logic [7:0]  f_seq_num;
    logic        d_rdy;
    logic        squash_val;
    logic [7:0]  squash_seq_num;

    logic        f_rdy, d_val;
    logic [31:0] d_inst, d_pc;
    logic [7:0]  d_seq_num;
    logic [2:0]  occupancy;

    logic        nb_f_rdy, nb_d_val;
    logic [31:0] nb_d_inst, nb_d_pc;
    logic [7:0]  nb_d_seq_num;
    logic [2:0]  nb_occupancy;

    decode_inst_buffer #(.p_depth(4), .p_seq_num_bits(8), .p_bypass(1)) dut (
        .clk(clk), .rst(rst),
        .f_val(f_val), .f_rdy(f_rdy), .f_inst(f_inst), .f_pc(f_pc), .f_seq_num(f_seq_num),
        .d_val(d_val), .d_rdy(d_rdy), .d_inst(d_inst), .d_pc(d_pc), .d_seq_num(d_seq_num),
        .squash_val(squash_val), .squash_seq_num(squash_seq_num), .occupancy(occupancy)
    );

    decode_inst_buffer #(.p_depth(4), .p_seq_num_bits(8), .p_bypass(0)) dut_nb (
        .clk(clk), .rst(rst),
        .f_val(f_val), .f_rdy(nb_f_rdy), .f_inst(f_inst), .f_pc(f_pc), .f_seq_num(f_seq_num),
        .d_val(nb_d_val), .d_rdy(d_rdy), .d_inst(nb_d_inst), .d_pc(nb_d_pc), .d_seq_num(nb_d_seq_num),
        .squash_val(squash_val), .squash_seq_num(squash_seq_num), .occupancy(nb_occupancy)
    );

    // Clock/reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];
    logic         pend_valid = 1'b0;
    logic [W-1:0] pend_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit younger(input logic [7:0] e, input logic [7:0] s);
        logic [7:0] d;
        d = e - s;
        return (d != 8'd0) && !d[7];
    endfunction

    // Driver: one call per cycle; inputs change 1 time unit after the edge.
    task automatic drive(input logic fv, input logic dr, input logic sq, input logic [7:0] sqs,
                         input logic [7:0] fs, input logic [31:0] pc);
        @(posedge clk);
        #1;
        f_val          = fv;
        d_rdy          = dr;
        squash_val     = sq;
        squash_seq_num = sqs;
        f_seq_num      = fs;
        f_pc           = pc;
        f_inst         = {24'hC0FFEE, fs};
        pend_valid     = fv && (exp_q.size() < 4) && !(sq && younger(fs, sqs));
        pend_data      = {fs, pc, {24'hC0FFEE, fs}};
    endtask

    function automatic logic [31:0] pc_of(input logic [7:0] s);
        return 32'h1000 + {22'd0, s, 2'b00};
    endfunction

    // Scoreboard: checks per-cycle state against the model queue, then applies
    // dequeue, squash trimming and the accepted enqueue.
    always @(negedge clk) begin : mon
        int sz;
        int cut;
        logic [W-1:0] it;
        if (!rst) begin
            sz = exp_q.size();
            check("sb_occupancy", 32'(occupancy), 32'(sz));
            check("sb_f_rdy", 32'(f_rdy), 32'(sz != 4));
            check("sb_d_val", 32'(d_val), 32'((sz != 0) || f_val));
            if (pend_valid && sz == 0) begin
                exp_q.push_back(pend_data);
                pend_valid = 1'b0;
            end
            if (d_rdy && exp_q.size() != 0) begin
                it = exp_q.pop_front();
                check("sb_d_seq", 32'(d_seq_num), 32'(it[71:64]));
                check("sb_d_pc", d_pc, it[63:32]);
                check("sb_d_inst", d_inst, it[31:0]);
            end
            if (squash_val) begin
                cut = -1;
                for (int i = 0; i < int'(exp_q.size()); i++)
                    if (cut < 0 && younger(exp_q[i][71:64], squash_seq_num)) cut = i;
                if (cut >= 0)
                    while (int'(exp_q.size()) > cut) void'(exp_q.pop_back());
            end
            if (pend_valid) exp_q.push_back(pend_data);
            pend_valid = 1'b0;
        end
    end

    typedef struct {
        logic       fv;
        logic       dr;
        logic       sq;
        logic [7:0] sqs;
        logic [7:0] fs;
        logic       edv;
        logic       efr;
        logic [2:0] eocc;
        logic [7:0] eds;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fv, input logic dr, input logic sq, input logic [7:0] sqs,
                                input logic [7:0] fs, input logic edv, input logic efr,
                                input logic [2:0] eocc, input logic [7:0] eds);
        vec_t v;
        v.fv = fv; v.dr = dr; v.sq = sq; v.sqs = sqs; v.fs = fs;
        v.edv = edv; v.efr = efr; v.eocc = eocc; v.eds = eds;
        return v;
    endfunction

    initial begin
        // Expected values describe the state seen during the row's cycle.
        //               fv dr sq sqs    fs     edv efr occ eds
        // fill 0..3, 4th offer rejected, then drain
        vecs.push_back(mk(1, 0, 0, 0,   0,   1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   1,   1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0,   2,   1, 1, 2, 0));
        vecs.push_back(mk(1, 0, 0, 0,   3,   1, 1, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0,   9,   1, 0, 4, 0));
        vecs.push_back(mk(0, 1, 0, 0,   0,   1, 0, 4, 0));
        vecs.push_back(mk(0, 1, 0, 0,   0,   1, 1, 3, 1));
        vecs.push_back(mk(0, 1, 0, 0,   0,   1, 1, 2, 2));
        vecs.push_back(mk(0, 1, 0, 0,   0,   1, 1, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0,   0,   0, 1, 0, 0));
        // full plus dequeue: seq 4 leaves, seq 8 rejected
        vecs.push_back(mk(1, 0, 0, 0,   4,   1, 1, 0, 4));
        vecs.push_back(mk(1, 0, 0, 0,   5,   1, 1, 1, 4));
        vecs.push_back(mk(1, 0, 0, 0,   6,   1, 1, 2, 4));
        vecs.push_back(mk(1, 0, 0, 0,   7,   1, 1, 3, 4));
        vecs.push_back(mk(1, 1, 0, 0,   8,   1, 0, 4, 4));
        vecs.push_back(mk(0, 0, 0, 0,   0,   1, 1, 3, 5));
        vecs.push_back(mk(0, 1, 0, 0,   0,   1, 1, 3, 5));
        vecs.push_back(mk(0, 1, 0, 0,   0,   1, 1, 2, 6));
        vecs.push_back(mk(0, 1, 0, 0,   0,   1, 1, 1, 7));
        vecs.push_back(mk(0, 0, 0, 0,   0,   0, 1, 0, 0));
        // selective squash at 11, then refill with 14
        vecs.push_back(mk(1, 0, 0, 0,   10,  1, 1, 0, 10));
        vecs.push_back(mk(1, 0, 0, 0,   11,  1, 1, 1, 10));
        vecs.push_back(mk(1, 0, 0, 0,   12,  1, 1, 2, 10));
        vecs.push_back(mk(1, 0, 0, 0,   13,  1, 1, 3, 10));
        vecs.push_back(mk(0, 0, 1, 11,  0,   1, 0, 4, 10));
        vecs.push_back(mk(1, 0, 0, 0,   14,  1, 1, 2, 10));
        vecs.push_back(mk(0, 0, 0, 0,   0,   1, 1, 3, 10));
        vecs.push_back(mk(0, 1, 0, 0,   0,   1, 1, 3, 10));
        vecs.push_back(mk(0, 1, 0, 0,   0,   1, 1, 2, 11));
        vecs.push_back(mk(0, 1, 0, 0,   0,   1, 1, 1, 14));
        vecs.push_back(mk(0, 0, 0, 0,   0,   0, 1, 0, 0));
        // wrap-around: squash 255 over 254,255,0,1; enqueue 2 dropped, 255 kept
        vecs.push_back(mk(1, 0, 0, 0,   254, 1, 1, 0, 254));
        vecs.push_back(mk(1, 0, 0, 0,   255, 1, 1, 1, 254));
        vecs.push_back(mk(1, 0, 0, 0,   0,   1, 1, 2, 254));
        vecs.push_back(mk(1, 0, 0, 0,   1,   1, 1, 3, 254));
        vecs.push_back(mk(0, 0, 1, 255, 0,   1, 0, 4, 254));
        vecs.push_back(mk(1, 0, 1, 255, 2,   1, 1, 2, 254));
        vecs.push_back(mk(1, 0, 1, 255, 255, 1, 1, 2, 254));
        vecs.push_back(mk(0, 0, 0, 0,   0,   1, 1, 3, 254));
        vecs.push_back(mk(0, 1, 0, 0,   0,   1, 1, 3, 254));
        vecs.push_back(mk(0, 1, 0, 0,   0,   1, 1, 2, 255));
        vecs.push_back(mk(0, 1, 0, 0,   0,   1, 1, 1, 255));
        vecs.push_back(mk(0, 0, 0, 0,   0,   0, 1, 0, 0));
        // squash together with dequeue; squash while empty
        vecs.push_back(mk(1, 0, 0, 0,   20,  1, 1, 0, 20));
        vecs.push_back(mk(1, 0, 0, 0,   21,  1, 1, 1, 20));
        vecs.push_back(mk(1, 0, 0, 0,   22,  1, 1, 2, 20));
        vecs.push_back(mk(0, 1, 1, 20,  0,   1, 1, 3, 20));
        vecs.push_back(mk(0, 0, 0, 0,   0,   0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 5,   0,   0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0,   0, 1, 0, 0));

        // reset state
        rst = 1'b1; f_val = 1'b0; d_rdy = 1'b0; squash_val = 1'b0;
        squash_seq_num = '0; f_seq_num = '0; f_pc = '0; f_inst = '0;
        #2;
        check("rst_d_val", 32'(d_val), 32'd0);
        check("rst_f_rdy", 32'(f_rdy), 32'd1);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_nb_d_val", 32'(nb_d_val), 32'd0);
        #10;
        rst = 1'b0;

        // bypass: zero latency with bypass, one cycle without
        drive(1, 1, 0, 0, 8'h40, 32'h200);
        #2;
        check("byp_d_val", 32'(d_val), 32'd1);
        check("byp_d_pc", d_pc, 32'h200);
        check("byp_nb_d_val", 32'(nb_d_val), 32'd0);
        drive(0, 1, 0, 0, 0, 0);
        #2;
        check("byp_occ_after", 32'(occupancy), 32'd0);
        check("byp_d_val_after", 32'(d_val), 32'd0);
        check("byp_nb_d_val_next", 32'(nb_d_val), 32'd1);
        check("byp_nb_d_pc_next", nb_d_pc, 32'h200);
        check("byp_nb_occ_next", 32'(nb_occupancy), 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        check("byp_nb_occ_drained", 32'(nb_occupancy), 32'd0);

        // table
        foreach (vecs[i]) begin
            drive(vecs[i].fv, vecs[i].dr, vecs[i].sq, vecs[i].sqs, vecs[i].fs, pc_of(vecs[i].fs));
            #2;
            check($sformatf("row%0d_d_val", i), 32'(d_val), 32'(vecs[i].edv));
            check($sformatf("row%0d_f_rdy", i), 32'(f_rdy), 32'(vecs[i].efr));
            check($sformatf("row%0d_occ", i), 32'(occupancy), 32'(vecs[i].eocc));
            if (vecs[i].edv)
                check($sformatf("row%0d_d_seq", i), 32'(d_seq_num), 32'(vecs[i].eds));
        end

        // asynchronous reset between edges with three entries held
        for (int s = 30; s < 33; s++) drive(1, 0, 0, 0, 8'(s), pc_of(8'(s)));
        drive(0, 0, 0, 0, 0, 0);
        #2;
        check("arst_occ_before", 32'(occupancy), 32'd3);
        rst = 1'b1;
        #1;
        check("arst_d_val", 32'(d_val), 32'd0);
        check("arst_occ", 32'(occupancy), 32'd0);
        check("arst_f_rdy", 32'(f_rdy), 32'd1);
        rst = 1'b0;
        exp_q.delete();
        pend_valid = 1'b0;

        // buffer usable again after reset
        drive(1, 0, 0, 0, 8'd41, pc_of(8'd41));
        drive(0, 0, 0, 0, 0, 0);
        #2;
        check("post_rst_occ", 32'(occupancy), 32'd1);
        check("post_rst_d_seq", 32'(d_seq_num), 32'd41);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
